// File: rtl/btn_valid_gen_if.sv
// Valid/ready event handshake between the button conditioner and its consumer.
// The master side produces events and the slave side accepts them.
interface btn_valid_gen_if;
    logic ready_i;
    logic valid_o;
    logic pressed_o;
    logic overrun_o;

    modport master (
        input  ready_i,
        output valid_o,
        output pressed_o,
        output overrun_o
    );

    modport slave (
        output ready_i,
        input  valid_o,
        input  pressed_o,
        input  overrun_o
    );
endinterface

// File: rtl/btn_valid_gen.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce, press event with valid/ready hold.
// Optional auto-repeat is built only when BTN_REPEAT_EN is defined.
module btn_valid_gen #(
    parameter int DEBOUNCE_CYCLES      = 250000,
    parameter int ACTIVE_LOW           = 0,
    parameter int REPEAT_DELAY_CYCLES  = 12500000,
    parameter int REPEAT_PERIOD_CYCLES = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_i,
    btn_valid_gen_if.master  bus
);

    localparam int   CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HELD     = 2'd1;
`ifdef BTN_REPEAT_EN
    localparam logic [1:0] S_RPT_WAIT = 2'd2;
    localparam logic [1:0] S_RPT      = 2'd3;
`endif

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_param
        $error("btn_valid_gen: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_pressed;
    logic [1:0]       r_state;
    logic             r_valid;
    logic             r_overrun;

    logic             w_sync_lvl;
    logic             w_differ;
    logic             w_toggle;
    logic             w_press;
    logic             w_release;
    logic [1:0]       w_state_nxt;
    logic             w_evt;

    assign w_sync_lvl = r_sync2 ^ RELEASED_RAW;
    assign w_differ   = (w_sync_lvl != r_pressed);
    assign w_toggle   = w_differ && (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_press    = w_toggle && !r_pressed;
    assign w_release  = w_toggle && r_pressed;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= RELEASED_RAW;
            r_sync2   <= RELEASED_RAW;
            r_db_cnt  <= '0;
            r_pressed <= 1'b0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            if (!w_differ || w_toggle) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_toggle) begin
                r_pressed <= ~r_pressed;
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_rpt_clr;

    // The repeat counter starts at the press edge; HELD is the first cycle of the delay.
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_rpt_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rpt_clr = 1'b1;
                if (w_press) begin
                    w_state_nxt = S_HELD;
                    w_evt       = 1'b1;
                end
            end
            S_HELD, S_RPT_WAIT: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_rpt_clr   = 1'b1;
                end else if (r_rpt_cnt == RPT_W'(REPEAT_DELAY_CYCLES - 1)) begin
                    w_state_nxt = S_RPT;
                    w_evt       = 1'b1;
                    w_rpt_clr   = 1'b1;
                end else begin
                    w_state_nxt = S_RPT_WAIT;
                end
            end
            S_RPT: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_rpt_clr   = 1'b1;
                end else if (r_rpt_cnt == RPT_W'(REPEAT_PERIOD_CYCLES - 1)) begin
                    w_evt     = 1'b1;
                    w_rpt_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rpt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_rpt_clr) begin
            r_rpt_cnt <= '0;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_nxt = S_HELD;
                    w_evt       = 1'b1;
                end
            end
            S_HELD: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new event wins over a same-cycle transfer; it is dropped only when the slot is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_evt && r_valid && !bus.ready_i;
            if (w_evt) begin
                r_valid <= 1'b1;
            end else if (bus.ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.valid_o   = r_valid;
    assign bus.pressed_o = r_pressed;
    assign bus.overrun_o = r_overrun;

endmodule

// File: tb/tb_btn_valid_gen.sv
// Directed and randomised bench for btn_valid_gen with DEBOUNCE_CYCLES=4.
// A sample-window reference model predicts pressed/valid/overrun on every edge.
module tb_btn_valid_gen;

    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic btn_i = 1'b0;

    btn_valid_gen_if u_if ();

    btn_valid_gen #(
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn_i(btn_i),
        .bus  (u_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int m_xfer   = 0;
    int obs_xfer = 0;

    // m_smp[0] is the raw pin sampled one edge ago, m_smp[i] i+1 edges ago.
    bit m_smp[$];
    bit m_pressed;
    bit m_valid;
    bit m_ovr;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_smp.delete();
        for (int i = 0; i <= D; i++) m_smp.push_back(1'b0);
        m_pressed = 1'b0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
    endtask

    // One clock edge: advance the model, then compare all outputs 1 time unit later.
    task automatic tick();
        bit tog;
        bit ev;
        if (u_if.valid_o === 1'b1 && u_if.ready_i === 1'b1) obs_xfer++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            // The level flips once the last D synchronised samples all disagree with it.
            tog = 1'b1;
            for (int i = 1; i <= D; i++) if (m_smp[i] == m_pressed) tog = 1'b0;
            ev = tog && !m_pressed;
            if (m_valid && u_if.ready_i) m_xfer++;
            m_ovr     = ev && m_valid && !u_if.ready_i;
            m_valid   = ev ? 1'b1 : (m_valid && !u_if.ready_i);
            m_pressed = m_pressed ^ tog;
            m_smp.push_front(btn_i);
            void'(m_smp.pop_back());
        end
        #1;
        check("model_pressed", u_if.pressed_o, m_pressed);
        check("model_valid",   u_if.valid_o,   m_valid);
        check("model_overrun", u_if.overrun_o, m_ovr);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int len;
        int base;
        u_if.ready_i = 1'b0;
        model_reset();

        // Reset then idle
        rst = 1'b1;
        ticks(3);
        check("reset_valid",   u_if.valid_o,   1'b0);
        check("reset_pressed", u_if.pressed_o, 1'b0);
        check("reset_overrun", u_if.overrun_o, 1'b0);
        rst = 1'b0;
        ticks(50);
        check("idle_valid", u_if.valid_o, 1'b0);

        // Clean press with ready high: edge 6 rise, edge 7 accepted
        u_if.ready_i = 1'b1;
        btn_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("press_pressed_e%0d", k), u_if.pressed_o, (k == 6));
            check($sformatf("press_valid_e%0d", k),   u_if.valid_o,   (k == 6));
        end
        tick();
        check("press_valid_e7",   u_if.valid_o,   1'b0);
        check("press_pressed_e7", u_if.pressed_o, 1'b1);
        btn_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("release_pressed_e%0d", k), u_if.pressed_o, (k < 6));
            check($sformatf("release_valid_e%0d", k),   u_if.valid_o,   1'b0);
        end

        // Bounce shorter than the debounce window
        u_if.ready_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            btn_i = ((c / 2) % 2 == 0);
            tick();
            check("bounce_pressed", u_if.pressed_o, 1'b0);
            check("bounce_valid",   u_if.valid_o,   1'b0);
            check("bounce_overrun", u_if.overrun_o, 1'b0);
        end
        btn_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bounce_tail_pressed", u_if.pressed_o, 1'b0);
        end

        // Backpressure: second press is dropped with one overrun pulse
        btn_i = 1'b1;
        ticks(6);
        check("bp_valid_first", u_if.valid_o, 1'b1);
        ticks(3);
        btn_i = 1'b0;
        ticks(8);
        btn_i = 1'b1;
        ticks(6);
        check("bp_overrun_pulse", u_if.overrun_o, 1'b1);
        check("bp_valid_held",    u_if.valid_o,   1'b1);
        tick();
        check("bp_overrun_end", u_if.overrun_o, 1'b0);
        btn_i = 1'b0;
        ticks(8);
        base = obs_xfer;
        u_if.ready_i = 1'b1;
        tick();
        check("bp_valid_fall", u_if.valid_o, 1'b0);
        tick();
        u_if.ready_i = 1'b0;
        check_int("bp_transfers", obs_xfer - base, 1);

        // Event on the same edge as a transfer keeps valid high
        btn_i = 1'b1;
        ticks(6);
        ticks(2);
        btn_i = 1'b0;
        ticks(8);
        check("sim_valid_pending", u_if.valid_o, 1'b1);
        btn_i = 1'b1;
        ticks(5);
        u_if.ready_i = 1'b1;
        tick();
        check("sim_valid_kept",  u_if.valid_o,   1'b1);
        check("sim_no_overrun",  u_if.overrun_o, 1'b0);
        tick();
        check("sim_second_accept", u_if.valid_o, 1'b0);
        u_if.ready_i = 1'b0;
        btn_i = 1'b0;
        ticks(8);

        // Reset mid-debounce with an event pending
        btn_i = 1'b1;
        ticks(6);
        btn_i = 1'b0;
        ticks(8);
        btn_i = 1'b1;
        ticks(3);
        rst = 1'b1;
        tick();
        check("rst_valid",   u_if.valid_o,   1'b0);
        check("rst_pressed", u_if.pressed_o, 1'b0);
        check("rst_overrun", u_if.overrun_o, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("rerise_pressed_e%0d", k), u_if.pressed_o, (k == 6));
            check($sformatf("rerise_valid_e%0d", k),   u_if.valid_o,   (k == 6));
        end
        u_if.ready_i = 1'b1;
        tick();
        u_if.ready_i = 1'b0;
        btn_i = 1'b0;
        ticks(8);

        // Randomised pin levels, hold lengths, backpressure and rare resets
        for (int s = 0; s < 400; s++) begin
            btn_i = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) begin
                u_if.ready_i = ($urandom_range(0, 2) == 0);
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst = 1'b0;
        u_if.ready_i = 1'b1;
        ticks(3);
        check_int("total_transfers", obs_xfer, m_xfer);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
